// File: rtl/csr_bank_pkg.sv
// Shared types and helpers for the csr_bank register bank.
// - access_e : per-register access mode (RW / RO / W1C)
// - acc_mode : derives the mode of register i from the RO/W1C masks
// - ByteSz   : byte width used for wb_sel_i byte enables
package csr_bank_pkg;

  localparam int unsigned ByteSz  = 8;
  // Upper bound on register count accepted by acc_mode().
  localparam int unsigned MaxRegs = 256;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } access_e;

  function automatic access_e acc_mode(input int unsigned i,
                                       input logic [MaxRegs-1:0] ro_mask,
                                       input logic [MaxRegs-1:0] w1c_mask);
    if (ro_mask[i])       return ACC_RO;
    else if (w1c_mask[i]) return ACC_W1C;
    else                  return ACC_RW;
  endfunction

endpackage

// File: rtl/csr_bank_reg.sv
// One register slice of csr_bank.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   we_i          : write strobe (one cycle, accepting edge)
//   sel_i, dat_i  : byte selects and write data
//   hw_i          : RO -> live value; W1C -> set bits; RW -> ignored
//   val_o         : current register value
// RO slices hold no state: the value is hw_i passed straight through.
module csr_bank_reg
  import csr_bank_pkg::*;
#(
  parameter int unsigned DataSz = 32,
  parameter access_e     Mode   = ACC_RW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [DataSz/ByteSz-1:0] sel_i,
  input  logic [DataSz-1:0]        dat_i,
  input  logic [DataSz-1:0]        hw_i,
  output logic [DataSz-1:0]        val_o
);

  localparam int unsigned SelSz = DataSz / ByteSz;

  if (Mode == ACC_RO) begin : g_ro
    logic unused_ro;
    assign unused_ro = ^{clk_i, rst_ni, we_i, sel_i, dat_i};
    assign val_o     = hw_i;
  end else begin : g_stor
    logic [DataSz-1:0] val_q, val_d, bmask;

    always_comb begin
      bmask = '0;
      for (int b = 0; b < SelSz; b++) bmask[b*ByteSz +: ByteSz] = {ByteSz{sel_i[b]}};
    end

    if (Mode == ACC_W1C) begin : g_w1c
      // Clear first, then OR in hardware sets so a same-cycle set wins.
      always_comb begin
        val_d = val_q;
        if (we_i) val_d = val_q & ~(dat_i & bmask);
        val_d = val_d | hw_i;
      end
    end else begin : g_rw
      logic unused_rw;
      assign unused_rw = ^hw_i;
      always_comb begin
        val_d = val_q;
        if (we_i) val_d = (val_q & ~bmask) | (dat_i & bmask);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) val_q <= '0;
      else         val_q <= val_d;
    end

    assign val_o = val_q;
  end

endmodule

// File: rtl/csr_bank.sv
// Wishbone B4 classic control/status register bank.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   wb_cyc_i .. wb_dat_i   : Wishbone slave inputs (word addressed)
//   wb_dat_o, wb_ack_o,
//   wb_err_o               : registered response, 1 cycle after accept
//   hw_dat_i               : per-register hardware value / W1C set bits
//   reg_bank_o             : flat register values, reg i at [DataSz*i +: DataSz]
//   reg_wr_o               : per-register write pulse, aligned with ack
//   irq_o                  : OR of all W1C bits (registered) when the
//                            CSR_BANK_IRQ_EN macro is defined, else 0
module csr_bank
  import csr_bank_pkg::*;
#(
  parameter int unsigned      AddrSz  = 4,
  parameter int unsigned      DataSz  = 32,
  parameter int unsigned      RegsNb  = 8,
  parameter logic [RegsNb-1:0] RoMask  = '0,
  parameter logic [RegsNb-1:0] W1cMask = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [DataSz/ByteSz-1:0]   wb_sel_i,
  input  logic [AddrSz-1:0]          wb_adr_i,
  input  logic [DataSz-1:0]          wb_dat_i,
  output logic [DataSz-1:0]          wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  input  logic [DataSz*RegsNb-1:0]   hw_dat_i,
  output logic [DataSz*RegsNb-1:0]   reg_bank_o,
  output logic [RegsNb-1:0]          reg_wr_o,
  output logic                       irq_o
);

  if ((RoMask & W1cMask) != '0) begin : g_mask_chk
    $error("csr_bank: RoMask and W1cMask overlap");
  end
  if ((DataSz % ByteSz) != 0) begin : g_width_chk
    $error("csr_bank: DataSz must be a multiple of 8");
  end
  if (RegsNb > (2 ** AddrSz) || RegsNb > MaxRegs) begin : g_regs_chk
    $error("csr_bank: RegsNb out of range");
  end

  logic [RegsNb-1:0][DataSz-1:0] bank;
  logic                          ack_q, ack_d, err_q, err_d, req, mapped;
  logic [DataSz-1:0]             dat_q, dat_d, rd_val;
  logic [RegsNb-1:0]             wr_q, wr_d;

  // A pending response blocks acceptance, giving at most one transfer per 2 cycles.
  assign req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign mapped = 32'(wb_adr_i) < RegsNb;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < RegsNb; i++)
      if (wb_adr_i == AddrSz'(i)) rd_val = bank[i];
  end

  always_comb begin
    ack_d = 1'b0;
    err_d = 1'b0;
    dat_d = '0;
    wr_d  = '0;
    if (req) begin
      if (mapped) begin
        ack_d = 1'b1;
        if (wb_we_i) begin
          for (int i = 0; i < RegsNb; i++) wr_d[i] = (wb_adr_i == AddrSz'(i));
        end else begin
          dat_d = rd_val;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      wr_q  <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
      wr_q  <= wr_d;
    end
  end

  // wr_d doubles as the slice write enable: it is already qualified by accept + mapped + we.
  for (genvar g = 0; g < RegsNb; g++) begin : g_reg
    csr_bank_reg #(
      .DataSz (DataSz),
      .Mode   (acc_mode(g, MaxRegs'(RoMask), MaxRegs'(W1cMask)))
    ) u_reg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (wr_d[g]),
      .sel_i  (wb_sel_i),
      .dat_i  (wb_dat_i),
      .hw_i   (hw_dat_i[DataSz*g +: DataSz]),
      .val_o  (bank[g])
    );
  end

  assign reg_bank_o = bank;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign reg_wr_o   = wr_q;

`ifdef CSR_BANK_IRQ_EN
  logic [RegsNb-1:0] flag_any;
  logic              irq_q;
  for (genvar g = 0; g < RegsNb; g++) begin : g_irq
    assign flag_any[g] = W1cMask[g] ? |bank[g] : 1'b0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= |flag_any;
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_csr_bank.sv
module tb_csr_bank;

  logic             clk = 0, rst_n = 0;
  logic             cyc = 0, stb = 0, we = 0;
  logic [3:0]       sel = 0, adr = 0;
  logic [31:0]      wdat = 0, rdat;
  logic             ack, err, irq;
  logic [7:0][31:0] hw = '0, bank, exp_bank;
  logic [7:0]       wr;
  logic             irq_on;
  int               checks = 0, errors = 0;

  always #5 clk = ~clk;

`ifdef CSR_BANK_IRQ_EN
  initial irq_on = 1'b1;
`else
  initial irq_on = 1'b0;
`endif

  csr_bank #(
    .AddrSz(4), .DataSz(32), .RegsNb(8), .RoMask(8'h08), .W1cMask(8'h04)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
    .wb_ack_o(ack), .wb_err_o(err), .hw_dat_i(hw), .reg_bank_o(bank),
    .reg_wr_o(wr), .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, let it be accepted, then drop the strobe.
  // Returns at posedge+1 of the response cycle.
  task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_wr", wr, 0);
    chk("rst_bank", bank, 0);
    chk("rst_irq", irq, 0);
    #3 rst_n = 1;
    step();

    // Reset asserted right after a write to reg 0 is accepted: no ack, all zero
    cyc = 1; stb = 1; we = 1; adr = 0; wdat = 32'h12345678; sel = 4'hF;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_ack", ack, 0);
    chk("midrst_bank", bank, 0);
    cyc = 0; stb = 0; we = 0;
    #3 rst_n = 1;
    step();
    chk("postrst_ack", ack, 0);
    chk("postrst_bank", bank, 0);
    chk("postrst_irq", irq, 0);

    // RW byte enables on reg 1
    xfer(1, 1, 32'h11223344, 4'hF);
    chk("rw_ack", ack, 1);
    chk("rw_err", err, 0);
    chk("rw_wr", wr, 8'h02);
    chk("rw_full", bank[1], 32'h11223344);
    step();
    chk("rw_ack_drop", ack, 0);
    chk("rw_wr_drop", wr, 0);
    xfer(1, 1, 32'hAABBCCDD, 4'b0101);
    chk("rwb_ack", ack, 1);
    chk("rwb_wr", wr, 8'h02);
    chk("rwb_val", bank[1], 32'h11BB33DD);
    step();
    chk("rd_pre_ack", ack, 0);
    xfer(0, 1, 32'h0, 4'hF);
    chk("rd_ack", ack, 1);
    chk("rd_dat", rdat, 32'h11BB33DD);
    chk("rd_wr", wr, 0);
    step();
    chk("rd_ack_drop", ack, 0);
    chk("rd_dat_drop", rdat, 0);
    xfer(1, 1, 32'hFFFFFFFF, 4'h0);
    chk("sel0_wr", wr, 8'h02);
    chk("sel0_val", bank[1], 32'h11BB33DD);
    step();

    // W1C on reg 2
    hw[2] = 32'h5;
    step();
    hw[2] = 32'h0;
    chk("w1c_set", bank[2], 32'h5);
    chk("irq_lag", irq, 0);
    step();
    chk("irq_set", irq, irq_on);
    xfer(1, 2, 32'h1, 4'hF);
    chk("w1c_clr1", bank[2], 32'h4);
    step();
    hw[2] = 32'h4;
    xfer(1, 2, 32'h4, 4'hF);
    hw[2] = 32'h0;
    chk("w1c_setwins", bank[2], 32'h4);
    step();
    xfer(1, 2, 32'h4, 4'hF);
    chk("w1c_clr4", bank[2], 32'h0);
    step();
    chk("irq_clr", irq, 0);

    // RO on reg 3
    hw[3] = 32'hCAFEF00D;
    xfer(0, 3, 32'h0, 4'hF);
    chk("ro_rd", rdat, 32'hCAFEF00D);
    step();
    xfer(1, 3, 32'h0, 4'hF);
    chk("ro_wr_ack", ack, 1);
    chk("ro_wr", wr, 8'h08);
    chk("ro_val", bank[3], 32'hCAFEF00D);
    step();

    // Unmapped addresses
    exp_bank = '0;
    exp_bank[1] = 32'h11BB33DD;
    exp_bank[3] = 32'hCAFEF00D;
    xfer(0, 9, 32'h0, 4'hF);
    chk("um_rd_err", err, 1);
    chk("um_rd_ack", ack, 0);
    chk("um_rd_dat", rdat, 0);
    step();
    chk("um_err_drop", err, 0);
    xfer(1, 9, 32'hFFFFFFFF, 4'hF);
    chk("um_wr_err", err, 1);
    chk("um_wr_ack", ack, 0);
    chk("um_wr_wr", wr, 0);
    chk("um_wr_bank", bank, exp_bank);
    step();
    xfer(0, 8, 32'h0, 4'hF);
    chk("um8_err", err, 1);
    chk("um8_ack", ack, 0);
    step();

    // Back-to-back reads with stb held
    cyc = 1; stb = 1; we = 0; adr = 1; sel = 4'hF;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_ack%0d", k), ack, k % 2);
      if (k % 2 == 1) chk($sformatf("b2b_dat%0d", k), rdat, 32'h11BB33DD);
      @(posedge clk); #1;
    end
    cyc = 0; stb = 0;
    chk("b2b_irq", irq, 0);
    step();
    chk("end_bank", bank, exp_bank);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
